keycode_cmd_decoder: RTL and testbench
======================================

Name: keycode_cmd_decoder

Overview:
- Receiving end of the Nios keycode PIO: consumes the 16-bit `keycode` word the Nios writes from the USB keyboard and turns it into simulation control.
- Controls produced: run/pause, simulation reset, single-step and game-speed selection.
- Filters mid-update PIO values, detects key-press edges, auto-repeats speed keys and saturates speed.
- Feeds the top level's `RESET_SIM`, `RUN`, the game clock_cutter `factor` and a step strobe.

Parameters:
STABLE_CYCLES, 4, cycles `keycode` must hold unchanged before acceptance (>=2)
RESET_HOLD, 16, cycles `reset_sim` stays high per reset command
REPEAT_CYCLES, 25000000, held-key auto-repeat period for speed keys
BASE_FACTOR, 50000000, slowdown factor at speed level 0
MAX_LEVEL, 7, highest speed level
FACTOR_W, 26, width of `slowdown_factor`

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous, active-low reset
keycode  in  16  [7:0] key A, [15:8] key B, USB HID usage codes, 0x00 = none
run  out  1  1 = simulation running
reset_sim  out  1  simulation reset request, active high
step_pulse  out  1  one-cycle single-step strobe
slowdown_factor  out  FACTOR_W  BASE_FACTOR >> speed_level
speed_level  out  3  current speed level
cmd_valid  out  1  one-cycle strobe per executed command
last_cmd  out  3  0 none, 1 reset, 2 pause toggle, 3 step, 4 faster, 5 slower

Behaviour:
Reset
- Async on Reset_n=0: run=0, reset_sim=0, step_pulse=0, speed_level=0, slowdown_factor=BASE_FACTOR, cmd_valid=0, last_cmd=0.
- Internal state: cand=0, accepted=0, counters=0, FSM=IDLE.
- All outputs are registered.

Stability filter
- `keycode` != cand: cand<=keycode, stab_cnt<=0.
- Otherwise stab_cnt increments, saturating at STABLE_CYCLES-1.
- Commit happens in the cycle when stab_cnt==STABLE_CYCLES-1 and cand != accepted: accepted<=cand.
- Latency: a value first sampled at edge k commits at edge k+STABLE_CYCLES-1. Command outputs update at edge k+STABLE_CYCLES.
- A value shorter than STABLE_CYCLES is never committed.

Press detection (on commit)
- A byte of cand is "pressed" if it is nonzero and equals neither byte of the old accepted value.
- Key map: 0x15 R = reset, 0x2C Space = pause toggle, 0x16 S = step, 0x2E '=' = faster, 0x2D '-' = slower.
- Unmapped codes are ignored.
- If two presses commit together, only the highest priority executes: reset > pause > step > faster > slower.
- Releases produce no command.

Command effects
- Every executed command: cmd_valid=1 for exactly 1 cycle and last_cmd=code, including saturated or no-op commands.
- Reset: FSM->RST_HOLD; reset_sim=1 for exactly RESET_HOLD cycles; run forced 0.
  - In RST_HOLD all other commands are dropped (no cmd_valid), but the filter keeps tracking.
  - speed_level is preserved.
  - Exit to IDLE with run=0.
  - A reset press during RST_HOLD is dropped and does not restart the count.
- Pause toggle: run<=~run.
- Step: step_pulse=1 for 1 cycle only if run==0. While running, cmd_valid still pulses and there is no step.
- Faster: speed_level+1, saturating at MAX_LEVEL.
- Slower: speed_level-1, saturating at 0.
- slowdown_factor updates in the same cycle as speed_level.

Auto-repeat
- rep_cnt clears on a faster/slower press.
- While the accepted value still contains that key, rep_cnt increments each cycle.
- On reaching REPEAT_CYCLES-1 it re-executes the command (cmd_valid pulses) and clears.
- Release, or any new commit, cancels the repeat.
- No repeat for reset, pause or step.

Test Plan:
1. Reset_n low mid-run -> all outputs return to reset values asynchronously; slowdown_factor=50000000.
2. keycode=0x002C held 10 cycles (STABLE_CYCLES=4) -> run 0->1 at edge k+4, cmd_valid 1 cycle, last_cmd=2. keycode=0x0000 then 0x002C again -> run=0. A 0x002C glitch of 3 cycles -> no change.
3. '=' pressed 9 times (release between presses) -> speed_level 1..7 then stays 7; factor 390625; cmd_valid 9 pulses. '-' ×8 -> level 0, factor 50000000.
4. keycode=0x2C15 (Space+R together) -> only reset executes: reset_sim high exactly 16 cycles, run=0, speed_level unchanged; Space pressed during hold -> ignored.
5. S with run=0 -> single step_pulse. S with run=1 -> cmd_valid, last_cmd=3, no step_pulse.
6. REPEAT_CYCLES=8: '=' held 30 cycles -> press step, then repeats every 8 cycles (levels 1,2,3,4). Key B added while held -> repeat cancelled.

Source files
------------

// File: rtl/keycode_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keycode_cmd_decoder
// Description : Turns the 16-bit Nios keycode PIO word (two USB HID usage
//               codes) into simulation controls: run/pause, timed reset,
//               single-step and a saturating speed level with auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_cmd_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int RESET_HOLD    = 16,
  parameter int REPEAT_CYCLES = 25000000,
  parameter int BASE_FACTOR   = 50000000,
  parameter int MAX_LEVEL     = 7,
  parameter int FACTOR_W      = 26
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [15:0]         keycode,
  output logic                run,
  output logic                reset_sim,
  output logic                step_pulse,
  output logic [FACTOR_W-1:0] slowdown_factor,
  output logic [2:0]          speed_level,
  output logic                cmd_valid,
  output logic [2:0]          last_cmd
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [SW-1:0]       STAB_LAST   = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0]       HOLD_LAST   = HW'(RESET_HOLD - 1);
  localparam logic [RW-1:0]       REP_LAST    = RW'(REPEAT_CYCLES - 1);
  localparam logic [2:0]          LEVEL_MAX   = 3'(MAX_LEVEL);
  localparam logic [FACTOR_W-1:0] FACTOR_BASE = FACTOR_W'(BASE_FACTOR);

  // Command codes double as priority: a lower code wins.
  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_RESET  = 3'd1;
  localparam logic [2:0] CMD_PAUSE  = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_FASTER = 3'd4;
  localparam logic [2:0] CMD_SLOWER = 3'd5;

  localparam logic [7:0] KEY_R     = 8'h15;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_EQUAL = 8'h2E;
  localparam logic [7:0] KEY_MINUS = 8'h2D;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    RST_HOLD = 1'b1
  } state_t;

  function automatic logic [2:0] key_to_cmd(input logic [7:0] key);
    case (key)
      KEY_R:     return CMD_RESET;
      KEY_SPACE: return CMD_PAUSE;
      KEY_S:     return CMD_STEP;
      KEY_EQUAL: return CMD_FASTER;
      KEY_MINUS: return CMD_SLOWER;
      default:   return CMD_NONE;
    endcase
  endfunction

  // A byte is a new press only if it was in neither slot of the previous word.
  function automatic logic [2:0] press_cmd(input logic [7:0] key, input logic [15:0] prev);
    if (key != 8'h00 && key != prev[7:0] && key != prev[15:8]) begin
      return key_to_cmd(key);
    end
    return CMD_NONE;
  endfunction

  logic [15:0]         cand;
  logic [15:0]         accepted;
  logic [SW-1:0]       stab_cnt;
  logic [SW-1:0]       stab_cnt_nxt;
  logic                commit;
  logic [2:0]          cmd_a;
  logic [2:0]          cmd_b;
  logic [2:0]          press_sel;
  logic                pend_valid;
  logic [2:0]          pend_cmd;
  state_t              state;
  state_t              state_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_cnt_nxt;
  logic                rep_active;
  logic [2:0]          rep_cmd;
  logic [RW-1:0]       rep_cnt;
  logic                rep_fire;
  logic [2:0]          exec_cmd;
  logic [2:0]          level_nxt;

  // Stability check on the raw PIO word and press decode against the last accepted word.
  always_comb begin
    stab_cnt_nxt = (stab_cnt == STAB_LAST) ? stab_cnt : stab_cnt + SW'(1);
    commit       = (keycode == cand) && (stab_cnt_nxt == STAB_LAST) && (cand != accepted);
    cmd_a        = press_cmd(cand[7:0], accepted);
    cmd_b        = press_cmd(cand[15:8], accepted);
    if (cmd_a == CMD_NONE) begin
      press_sel = cmd_b;
    end else if (cmd_b == CMD_NONE) begin
      press_sel = cmd_a;
    end else begin
      press_sel = (cmd_a < cmd_b) ? cmd_a : cmd_b;
    end
  end

  // Candidate tracking, commit of stable words and a one-cycle pending command.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cand       <= '0;
      stab_cnt   <= '0;
      accepted   <= '0;
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_NONE;
    end else begin
      if (keycode != cand) begin
        cand     <= keycode;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt_nxt;
      end
      if (commit) begin
        accepted <= cand;
      end
      pend_valid <= commit && (press_sel != CMD_NONE);
      pend_cmd   <= press_sel;
    end
  end

  // Control FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state logic and selection of the command executed this cycle.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    exec_cmd     = CMD_NONE;
    rep_fire     = rep_active && !commit && (rep_cnt == REP_LAST);
    case (state)
      IDLE: begin
        if (pend_valid) begin
          exec_cmd = pend_cmd;
        end else if (rep_fire) begin
          exec_cmd = rep_cmd;
        end
        if (exec_cmd == CMD_RESET) begin
          state_nxt    = RST_HOLD;
          hold_cnt_nxt = '0;
        end
      end
      RST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
    endcase
  end

  // Saturating speed level update.
  always_comb begin
    level_nxt = speed_level;
    if (exec_cmd == CMD_FASTER && speed_level != LEVEL_MAX) begin
      level_nxt = speed_level + 3'd1;
    end else if (exec_cmd == CMD_SLOWER && speed_level != 3'd0) begin
      level_nxt = speed_level - 3'd1;
    end
  end

  // Registered control outputs driven by the executed command.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run             <= 1'b0;
      reset_sim       <= 1'b0;
      step_pulse      <= 1'b0;
      speed_level     <= 3'd0;
      slowdown_factor <= FACTOR_BASE;
      cmd_valid       <= 1'b0;
      last_cmd        <= CMD_NONE;
    end else begin
      cmd_valid       <= (exec_cmd != CMD_NONE);
      step_pulse      <= 1'b0;
      reset_sim       <= (state_nxt == RST_HOLD);
      speed_level     <= level_nxt;
      slowdown_factor <= FACTOR_BASE >> level_nxt;
      if (exec_cmd != CMD_NONE) begin
        last_cmd <= exec_cmd;
      end
      case (exec_cmd)
        CMD_RESET: run        <= 1'b0;
        CMD_PAUSE: run        <= ~run;
        CMD_STEP:  step_pulse <= ~run;
        default:   ;
      endcase
    end
  end

  // Auto-repeat for held speed keys; any commit or a reset hold cancels it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_active <= 1'b0;
      rep_cmd    <= CMD_NONE;
      rep_cnt    <= '0;
    end else begin
      if (commit || state == RST_HOLD) begin
        rep_active <= 1'b0;
        rep_cnt    <= '0;
      end else if (exec_cmd == CMD_FASTER || exec_cmd == CMD_SLOWER) begin
        rep_active <= 1'b1;
        rep_cmd    <= exec_cmd;
        rep_cnt    <= '0;
      end else if (rep_active) begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keycode_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_cmd_decoder
// Description : Directed-stimulus bench for keycode_cmd_decoder; expected
//               command effects are queued at stimulus time and checked by a
//               monitor whenever cmd_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_cmd_decoder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        run;
  logic        reset_sim;
  logic        step_pulse;
  logic [25:0] slowdown_factor;
  logic [2:0]  speed_level;
  logic        cmd_valid;
  logic [2:0]  last_cmd;

  keycode_cmd_decoder #(
    .STABLE_CYCLES(4),
    .RESET_HOLD(16),
    .REPEAT_CYCLES(8),
    .BASE_FACTOR(50000000),
    .MAX_LEVEL(7),
    .FACTOR_W(26)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .run(run),
    .reset_sim(reset_sim),
    .step_pulse(step_pulse),
    .slowdown_factor(slowdown_factor),
    .speed_level(speed_level),
    .cmd_valid(cmd_valid),
    .last_cmd(last_cmd)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [2:0]  cmd;
    logic        run;
    logic [2:0]  lvl;
    logic [25:0] fac;
    logic        step;
    logic        rsim;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int rs_len = 0;
  int rs_windows = 0;

  // Hand-computed 50000000 >> level.
  logic [25:0] fac_tab [0:7] = '{26'd50000000, 26'd25000000, 26'd12500000, 26'd6250000,
                                 26'd3125000, 26'd1562500, 26'd781250, 26'd390625};

  logic m_run = 1'b0;
  int   m_lvl = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue the expected visible effect of one executed command.
  task automatic expect_cmd(input logic [2:0] c);
    exp_t e;
    e.step = 1'b0;
    e.rsim = 1'b0;
    case (c)
      3'd1: begin m_run = 1'b0; e.rsim = 1'b1; end
      3'd2: m_run = ~m_run;
      3'd3: e.step = ~m_run;
      3'd4: if (m_lvl < 7) m_lvl++;
      3'd5: if (m_lvl > 0) m_lvl--;
      default: ;
    endcase
    e.cmd  = c;
    e.run  = m_run;
    e.lvl  = m_lvl[2:0];
    e.fac  = fac_tab[m_lvl];
    q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] v, input int n);
    keycode = v;
    repeat (n) @(negedge Clk);
  endtask

  // Short press followed by a release long enough to be committed.
  task automatic tap(input logic [15:0] v, input logic [2:0] c);
    if (c != 3'd0) expect_cmd(c);
    drive(v, 5);
    drive(16'h0000, 6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_run"}, run, 0);
    check({tag, "_reset_sim"}, reset_sim, 0);
    check({tag, "_step"}, step_pulse, 0);
    check({tag, "_level"}, speed_level, 0);
    check({tag, "_factor"}, slowdown_factor, 50000000);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_last_cmd"}, last_cmd, 0);
  endtask

  // Monitor: every cmd_valid pulse is matched against the head of the queue.
  always @(negedge Clk) begin
    if (Reset_n && cmd_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got last_cmd=%0d expected no command", last_cmd);
      end else begin
        mon_e = q.pop_front();
        check("mon_last_cmd", last_cmd, mon_e.cmd);
        check("mon_run", run, mon_e.run);
        check("mon_level", speed_level, mon_e.lvl);
        check("mon_factor", slowdown_factor, mon_e.fac);
        check("mon_step", step_pulse, mon_e.step);
        check("mon_reset_sim", reset_sim, mon_e.rsim);
      end
    end else if (Reset_n && step_pulse) begin
      total++;
      bad++;
      $display("FAIL stray_step: got step_pulse=1 expected 0 without cmd_valid");
    end
  end

  // Every reset_sim window must last exactly the hold length.
  always @(negedge Clk) begin
    if (reset_sim) begin
      rs_len++;
    end else if (rs_len != 0) begin
      check("reset_sim_len", rs_len, 16);
      rs_windows++;
      rs_len = 0;
    end
  end

  initial begin
    // Power-on reset values
    repeat (3) @(negedge Clk);
    check_reset_vals("por");
    Reset_n = 1'b1;
    drive(16'h0000, 3);

    // Pause toggle with latency check: sampled at edge k, outputs at k+4
    expect_cmd(3'd2);
    keycode = 16'h002C;
    repeat (4) @(negedge Clk);
    check("pause_run_early", run, 0);
    check("pause_valid_early", cmd_valid, 0);
    @(negedge Clk);
    check("pause_run_at_k4", run, 1);
    drive(16'h002C, 5);
    drive(16'h0000, 6);
    tap(16'h002C, 3'd2);
    // 3-cycle glitch must be filtered
    drive(16'h002C, 3);
    drive(16'h0000, 6);
    check("glitch_run", run, 0);

    // Faster x9 saturates at 7, slower x8 saturates at 0
    for (int i = 0; i < 9; i++) tap(16'h002E, 3'd4);
    check("fast_sat_level", speed_level, 7);
    check("fast_sat_factor", slowdown_factor, 390625);
    for (int i = 0; i < 8; i++) tap(16'h002D, 3'd5);
    check("slow_sat_level", speed_level, 0);
    check("slow_sat_factor", slowdown_factor, 50000000);

    // Step while paused, then while running
    tap(16'h0016, 3'd3);
    tap(16'h002C, 3'd2);
    tap(16'h0016, 3'd3);
    check("step_running_run", run, 1);
    tap(16'h002E, 3'd4);
    tap(16'h002E, 3'd4);

    // Space+R together: only reset; Space during hold is dropped
    expect_cmd(3'd1);
    drive(16'h2C15, 6);
    drive(16'h0000, 6);
    drive(16'h002C, 6);
    drive(16'h0000, 16);
    check("rst_run_after", run, 0);
    check("rst_reset_sim_after", reset_sim, 0);
    check("rst_level_kept", speed_level, 2);
    check("rst_windows", rs_windows, 1);

    // Held '=' auto-repeats every 8 cycles; adding key B cancels it
    tap(16'h002D, 3'd5);
    tap(16'h002D, 3'd5);
    for (int i = 0; i < 4; i++) expect_cmd(3'd4);
    drive(16'h002E, 30);
    drive(16'h042E, 12);
    drive(16'h0000, 6);
    check("repeat_level", speed_level, 4);
    check("repeat_factor", slowdown_factor, 3125000);

    // Asynchronous reset mid-run
    tap(16'h002C, 3'd2);
    check("pre_async_run", run, 1);
    #3 Reset_n = 1'b0;
    #1 check_reset_vals("async");
    m_run = 1'b0;
    m_lvl = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(16'h0000, 2);
    tap(16'h002C, 3'd2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge Clk);
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
